// File: rtl/imem_loader.sv
// Byte-stream loader for the big-endian 32-bit instruction memory: packs bytes into words,
// writes them sequentially and stalls the CPU meanwhile. Optional macro: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MEM_BYTES = 65536
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    input  logic        byte_last,
    output logic        byte_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic [15:0] word_count,
    output logic        cpu_stall,
    output logic [7:0]  checksum
);

    typedef enum logic [1:0] {StIdle, StLoad, StWrite, StDone} state_e;

    state_e      r_state;
    state_e      w_state_next;
    logic [1:0]  r_cnt;
    logic [31:0] r_shreg;
    logic [31:0] r_addr;
    logic        r_last;
    logic        r_wr_en;
    logic [31:0] r_wr_addr;
    logic [31:0] r_wr_data;
    logic        r_overflow;
    logic [15:0] r_word_count;

    logic        w_accept;
    logic        w_word_end;
    logic        w_start_ok;
    logic        w_ovf_hit;
    logic [31:0] w_shift;
    logic [31:0] w_packed;
    logic [32:0] w_limit;

    // 33-bit compare so a region ending exactly at 2^32 does not wrap.
    assign w_limit    = {1'b0, BASE_ADDR} + 33'(MEM_BYTES);
    assign w_ovf_hit  = ({1'b0, r_addr} >= w_limit);
    assign w_accept   = (r_state == StLoad) && byte_valid;
    assign w_word_end = w_accept && (byte_last || (r_cnt == 2'd3));
    assign w_start_ok = start && ((r_state == StIdle) || (r_state == StDone));
    assign w_shift    = {r_shreg[23:0], byte_in};

    // Received bytes land in the high-order positions; unfilled low bytes are NOP padding.
    always_comb begin
        w_packed = w_shift;
        unique case (r_cnt)
            2'd0: w_packed = {byte_in, 24'h00_0000};
            2'd1: w_packed = {r_shreg[7:0], byte_in, 16'h0000};
            2'd2: w_packed = {r_shreg[15:0], byte_in, 8'h00};
            2'd3: w_packed = w_shift;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (start) w_state_next = StLoad;
            StLoad:  if (w_word_end) w_state_next = StWrite;
            StWrite: w_state_next = (r_last || r_overflow) ? StDone : StLoad;
            StDone:  if (start) w_state_next = StLoad;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= StIdle;
            r_cnt        <= 2'd0;
            r_shreg      <= 32'h0;
            r_addr       <= BASE_ADDR;
            r_last       <= 1'b0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= 32'h0;
            r_wr_data    <= 32'h0;
            r_overflow   <= 1'b0;
            r_word_count <= 16'h0;
        end else begin
            r_state <= w_state_next;
            r_wr_en <= 1'b0;
            if (w_start_ok) begin
                r_word_count <= 16'h0;
                r_overflow   <= 1'b0;
                r_addr       <= BASE_ADDR;
                r_cnt        <= 2'd0;
                r_shreg      <= 32'h0;
                r_last       <= 1'b0;
            end
            if (w_accept) begin
                r_shreg <= w_shift;
                r_cnt   <= r_cnt + 2'd1;
                if (w_word_end) begin
                    r_last <= byte_last;
                    if (w_ovf_hit) begin
                        r_overflow <= 1'b1;
                    end else begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= r_addr;
                        r_wr_data <= w_packed;
                    end
                end
            end
            if (r_state == StWrite) begin
                r_cnt <= 2'd0;
                // An overflowed word was never written, so it is not counted.
                if (!r_overflow) begin
                    r_addr       <= r_addr + 32'd4;
                    r_word_count <= r_word_count + 16'd1;
                end
            end
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] r_checksum;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_checksum <= 8'h00;
        end else if (w_start_ok) begin
            r_checksum <= 8'h00;
        end else if (w_accept) begin
            r_checksum <= r_checksum + byte_in;
        end
    end

    assign checksum = r_checksum;
`else
    assign checksum = 8'h00;
`endif

    assign byte_ready = (r_state == StLoad);
    assign busy       = (r_state == StLoad) || (r_state == StWrite);
    assign cpu_stall  = busy;
    assign done       = (r_state == StDone);
    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign overflow   = r_overflow;
    assign word_count = r_word_count;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the byte-addressed, big-endian 32-bit instruction memory.
- Accepts a byte stream from a host or test harness over a valid/ready handshake and packs each 4 bytes into one instruction word.
- Issues single-cycle word writes at sequential word addresses and holds the CPU in stall until the image is fully loaded.
- Replaces file-based preload when a program must be loaded at run time.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first word written; must be 4-aligned.
- MEM_BYTES, 65536, instruction memory size in bytes; a write at or beyond BASE_ADDR+MEM_BYTES is an overflow.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin a load session; sampled only in IDLE or DONE.
- byte_in  input  8  next image byte; first byte of each word is the most significant.
- byte_valid  input  1  byte_in is valid.
- byte_last  input  1  qualifies byte_in as the final byte of the image; meaningful only with byte_valid.
- byte_ready  output  1  loader can accept a byte this cycle.
- wr_en  output  1  one-cycle word write strobe to instruction memory.
- wr_addr  output  32  byte address of the word being written (4-aligned).
- wr_data  output  32  word data; wr_data[31:24] goes to wr_addr, wr_data[7:0] goes to wr_addr+3.
- busy  output  1  high from start acceptance until DONE.
- done  output  1  level; high in DONE state.
- overflow  output  1  sticky; image exceeded memory.
- word_count  output  16  number of words written this session.
- cpu_stall  output  1  equals busy.
- checksum  output  8  see Optional Feature.

Behaviour:
- Reset values: all outputs 0. State goes to IDLE; byte counter = 0; shift register = 0; next address = BASE_ADDR.
- Handshake: a byte transfers on a clock edge where byte_valid && byte_ready. byte_ready is combinational from state only (high in LOAD only) and must not depend on byte_valid.
- IDLE: when start=1, go to LOAD. Set word_count=0, overflow=0, next address=BASE_ADDR, byte counter=0. busy rises the next cycle.
- LOAD: each accepted byte shifts in: shreg = {shreg[23:0], byte_in}, and the counter increments modulo 4.
  - Go to WRITE when the 4th byte is accepted (counter was 3) or when byte_last is accepted.
  - If byte_last arrives with counter k<3, pad the remaining 3-k low-order bytes with 8'h00 (MIPS NOP fill) so that the received bytes occupy the high-order positions.
- WRITE: exactly one cycle. wr_en=1, wr_addr=next address, wr_data=packed word. byte_ready=0.
  - Next cycle: next address += 4, word_count += 1, counter=0.
  - Next state is DONE if the word was last-terminated, otherwise LOAD.
  - Maximum throughput is therefore 4 bytes per 5 cycles.
- Overflow: if next address >= BASE_ADDR+MEM_BYTES on entry to WRITE, suppress wr_en, set overflow=1, and go to DONE. Remaining stream bytes are not accepted.
- DONE: done=1, busy=0. start=1 restarts exactly as from IDLE (done drops the next cycle). Otherwise stay in DONE.
- start while in LOAD or WRITE is ignored.
- byte_last without byte_valid is ignored.
- wr_en, wr_addr and wr_data are registered outputs. wr_addr and wr_data hold their last values when wr_en=0.
- Reset mid-session: return to IDLE in the same edge. The partial word is discarded and no write is issued on the reset cycle or afterwards.
- An empty image (start then DONE with no bytes) is not possible: the session ends only on byte_last.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined: checksum is a running 8-bit modular sum of every accepted byte (pad bytes excluded). It clears on start acceptance, holds in DONE, and clears on reset.
- Undefined: checksum is constant 8'h00 and no adder is synthesized. Port list is unchanged.

Test Plan:
- Reset, start, stream 20 8C 00 04 with last on 04 and valid held high → one wr_en; wr_addr=0, wr_data=32'h208C0004; word_count=1; done=1; byte_ready low during WRITE.
- Stream 8 bytes 00..07 with last on 07 → writes 32'h00010203 @0 and 32'h04050607 @4, each exactly one cycle; cpu_stall high until done.
- Stream AA BB CC with last on CC → single write 32'hAABBCC00 @0 (zero pad); word_count=1.
- BASE_ADDR=0, MEM_BYTES=8, stream 12 bytes → writes @0 and @4 only; third word produces no wr_en; overflow=1; done=1.
- Assert reset after 2 bytes of a word → no wr_en; all outputs 0. A new start plus 4 bytes writes to BASE_ADDR with correct data.
- With IMEM_LOADER_CHECKSUM_EN: stream FF 01 10 20 (last) → checksum=8'h30. Without the macro, checksum=0.
